// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// channel and the {pc, inst} stream toward decode.
interface ifu_fetch_queue_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_resp_valid;
    logic [INST_LEN-1:0] imem_resp_data;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [INST_LEN-1:0] out_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output out_valid, out_pc, out_inst,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  out_valid, out_pc, out_inst,
        output out_ready
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues in-order word requests and
// buffers returned instructions with their PCs for decode; flushes on redirect.
//
//   state | meaning
//   RUN   | normal fetch; requests issue while the queue has room
//   DRAIN | after a redirect, discarding responses still owed by memory
module ifu_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    ifu_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [XLEN-1:0]     fetch_pc;
    logic [PW-1:0]       alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0]       count, pend, drop_cnt, drop_nxt;
    logic [XLEN-1:0]     pc_mem   [DEPTH];
    logic [INST_LEN-1:0] inst_mem [DEPTH];
    logic                req_fire, resp_fire, out_fire, fill_en;

    // Gated by reset so no request is presented while the core is held in reset.
    assign bus.imem_req_valid = rst & (state == RUN) & (count < CW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    // pend counts allocated-but-unfilled entries, so the head is filled when count > pend.
    assign bus.out_valid      = (count > pend);
    assign bus.out_pc         = pc_mem[head_ptr];
    assign bus.out_inst       = inst_mem[head_ptr];

    assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
    assign resp_fire = bus.imem_resp_valid;
    assign out_fire  = bus.out_valid & bus.out_ready;
    assign fill_en   = resp_fire & (state == RUN) & (pend != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (bus.redirect_valid) begin
            if (state == RUN) drop_nxt = pend + CW'(req_fire) - CW'(fill_en);
            else              drop_nxt = drop_cnt - CW'(resp_fire);
            state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && resp_fire) begin
            drop_nxt = drop_cnt - CW'(1);
            if (drop_nxt == '0) state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            pend      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (req_fire) pc_mem[alloc_ptr] <= fetch_pc;
            if (fill_en)  inst_mem[fill_ptr] <= bus.imem_resp_data;
            if (bus.redirect_valid) begin
                fetch_pc  <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                head_ptr  <= '0;
                count     <= '0;
                pend      <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                alloc_ptr <= alloc_ptr + PW'(req_fire);
                fill_ptr  <= fill_ptr + PW'(fill_en);
                head_ptr  <= head_ptr + PW'(out_fire);
                count     <= count + CW'(req_fire) - CW'(out_fire);
                pend      <= pend + CW'(req_fire) - CW'(fill_en);
            end
        end
    end
endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Instruction fetch unit that sits directly upstream of the decoder in the RV64 core. It owns the fetch PC, issues word requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs in an in-order queue. It presents `{pc, inst}` pairs to decode through a valid/ready handshake and flushes everything on a redirect from the PC/branch logic.

## Interface
- `XLEN`, 64, address/PC width
- `INST_LEN`, 32, instruction width
- `RESET_PC`, 64'h8000_0000, first fetch address after reset
- `DEPTH`, 4, queue entries (power of 2, ≥2); bounds total in-flight plus buffered instructions

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- `imem_req_valid`  out  1  request pending
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  XLEN  word address of request
- `imem_resp_valid`  in  1  response data valid (always accepted, no backpressure)
- `imem_resp_data`  in  INST_LEN  instruction word
- `out_valid`  out  1  head entry holds a returned instruction
- `out_ready`  in  1  decode consumes head
- `out_pc`  out  XLEN  PC of head instruction
- `out_inst`  out  INST_LEN  head instruction

## Operation
- Fire events: `req_fire = imem_req_valid & imem_req_ready`; `resp_fire = imem_resp_valid`; `out_fire = out_valid & out_ready`.
- Queue: circular, `DEPTH` entries, three pointers: alloc (tail), fill, head; occupancy count 0..DEPTH. An entry is allocated with its PC on `req_fire`, marked filled on `resp_fire` (oldest unfilled entry), freed on `out_fire`.
- `fetch_pc`: `imem_req_addr = fetch_pc`; +4 on `req_fire`; on `redirect_valid` loaded with `{redirect_pc[XLEN-1:2],2'b00}` (redirect wins over increment).
- `imem_req_valid = (state==RUN) & (count < DEPTH)`; `count` is the registered occupancy (no same-cycle credit from `out_fire`). Independent of `imem_req_ready` and `redirect_valid`.
- Memory returns responses strictly in request order, earliest the cycle after acceptance.
- `out_valid = (count != 0) & head_filled`; `out_pc`/`out_inst` read from head entry.
- States:
  - RUN: normal fetch.
  - DRAIN: entered on redirect when in-flight responses remain; requests blocked; each `resp_fire` decrements `drop_cnt` and the data is discarded; leave to RUN when `drop_cnt` reaches 0 (a response arriving in the last drop cycle is discarded, request may issue next cycle).
- Redirect in cycle T (any state): a handshake `out_fire` in T completes normally; a `req_fire` in T counts as in flight and will be dropped; queue emptied (count 0, pointers reset) at end of T; `drop_cnt <= inflight + req_fire - resp_fire`, where `inflight` = allocated-but-unfilled entries (in RUN) or current `drop_cnt` (in DRAIN; req_fire is 0 there). Next state DRAIN if that value ≠0, else RUN.
- Counters sized `clog2(DEPTH)+1` bits; pointers wrap modulo DEPTH.

## Timing
- Reset (rst=0) values: `fetch_pc=RESET_PC`, state RUN, count 0, pointers 0, `drop_cnt 0`, entry storage 0; outputs `imem_req_valid=0` while reset asserted, `out_valid=0`, `out_pc=0`, `out_inst=0`, `imem_req_addr=RESET_PC`.
- First cycle after release: `imem_req_valid=1`, addr RESET_PC.
- Latency: request accepted T, response T+k (k≥1), `out_valid` at T+k+1.
- Throughput with DEPTH=4 and k=1, `out_ready` held 1: one instruction per cycle sustained.
- Full: count==DEPTH → `imem_req_valid=0` until an `out_fire`.
- `out_valid`, once asserted, holds with stable `out_pc`/`out_inst` until `out_fire` or redirect.
- Reset mid-operation: all state returns to reset values immediately; responses arriving after release for pre-reset requests are the memory's responsibility (memory reset with core).

## Test plan
- Reset release, k=1 memory, `out_ready=1` → out stream pc 0x80000000, 0x80000004, 0x80000008… one per cycle, first `out_valid` 2 cycles after release.
- `out_ready=0` for 10 cycles → exactly 4 requests issued, `imem_req_valid` drops, `out_pc` held at 0x80000000; release → 4 entries drain in order, fetch resumes at 0x80000010.
- Memory k=3, 3 requests in flight, redirect to 0x80001002 → 3 responses discarded, first new request addr 0x80001000 only after last drop, next `out_pc` 0x80001000.
- Redirect in same cycle as `req_fire` and a `resp_fire` with 1 in flight → `drop_cnt=1`, exactly one later response discarded.
- Redirect with `out_fire` same cycle → consumed instruction counted once, no stale instruction appears after redirect.
- `rst` pulled low while queue full and DRAIN-free → `out_valid=0`, `imem_req_valid=0` immediately; after release fetch restarts at RESET_PC.
